adder_arbiter: RTL and testbench

Shares one 32-bit signed ripple-carry adder datapath between NUM_REQ independent requesters. Each requester issues add or subtract operations over a valid/ready handshake. The arbiter grants one requester per cycle using round-robin priority, drives the shared adder, and captures the result in a single output register tagged with the requester ID. The block sits between the ALU front-end issue ports and the shared adder slice.

---
 rtl/adder_arbiter.sv | 140 ++++++++++++++
 tb/tb_adder_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one ripple-carry add/sub datapath; result lands in a tagged output register 1 cycle after transfer.
// A held result with res_ready low stalls all grants; a draining result frees the slot in the same cycle.
module adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_sub,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [ID_W-1:0]          res_id,
  output logic [WIDTH-1:0]         res_sum,
  output logic                     res_cout,
  output logic                     res_ovf
);

  localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic               res_valid_q, res_valid_d;
  logic [ID_W-1:0]    res_id_q, res_id_d;
  logic [WIDTH-1:0]   res_sum_q, res_sum_d;
  logic               res_cout_q, res_cout_d;
  logic               res_ovf_q, res_ovf_d;

  logic [NUM_REQ-1:0] rot_vld;
  logic               gnt_any;
  logic [ID_W-1:0]    gnt_idx;
  logic [ID_W:0]      cand;
  logic [ID_W:0]      ptr_inc;
  logic               slot_free;
  logic               xfer;

  logic [WIDTH-1:0]   a_sel, b_sel, b_eff, sum;
  logic               sub_sel;
  logic [WIDTH:0]     carry;
  logic               ovf;

  // Rotate valids so bit k is requester (ptr+k) mod NUM_REQ; the lowest set k wins.
  always_comb begin
    rot_vld = NUM_REQ'({req_valid, req_valid} >> ptr_q);
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (rot_vld[k]) begin
        cand = {1'b0, ptr_q} + (ID_W+1)'(k);
        if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
        gnt_any = 1'b1;
        gnt_idx = cand[ID_W-1:0];
      end
    end
  end

  assign slot_free = !res_valid_q || res_ready;

  always_comb begin
    req_ready = '0;
    if (!rst && slot_free && gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  assign xfer = |req_ready;

  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    sub_sel = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        a_sel   = req_a[i*WIDTH +: WIDTH];
        b_sel   = req_b[i*WIDTH +: WIDTH];
        sub_sel = req_sub[i];
      end
    end
  end

  // Subtract is A + ~B + 1, so carry-out of 1 means no borrow.
  always_comb begin
    b_eff    = sub_sel ? ~b_sel : b_sel;
    carry    = '0;
    sum      = '0;
    carry[0] = sub_sel;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]     = a_sel[i] ^ b_eff[i] ^ carry[i];
      carry[i+1] = (a_sel[i] & b_eff[i]) | (carry[i] & (a_sel[i] ^ b_eff[i]));
    end
    ovf = (a_sel[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_sel[WIDTH-1]);
  end

  always_comb begin
    ptr_d       = ptr_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_sum_d   = res_sum_q;
    res_cout_d  = res_cout_q;
    res_ovf_d   = res_ovf_q;
    ptr_inc     = {1'b0, gnt_idx} + (ID_W+1)'(1);
    if (xfer) begin
      res_valid_d = 1'b1;
      res_id_d    = gnt_idx;
      res_sum_d   = sum;
      res_cout_d  = carry[WIDTH];
      res_ovf_d   = ovf;
      ptr_d       = (ptr_inc == NUM_REQ_W) ? '0 : ptr_inc[ID_W-1:0];
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
      res_ovf_q   <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_sum_q   <= res_sum_d;
      res_cout_q  <= res_cout_d;
      res_ovf_q   <= res_ovf_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  assign res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: arithmetic corners, round-robin order, stall, and reset.
module tb_adder_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   req_sub;
  logic         res_valid;
  logic         res_ready;
  logic [1:0]   res_id;
  logic [31:0]  res_sum;
  logic         res_cout;
  logic         res_ovf;

  int checks;
  int failures;

  adder_arbiter #(.NUM_REQ(4), .ID_W(2), .WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .res_ovf   (res_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_sub[i]        = s;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    res_ready = 1'b1;

    // reset state; no grants while rst is high
    #1 check("rst_ready", req_ready, 4'h0);
    tick();
    tick();
    check("rst_valid", res_valid, 0);
    check("rst_id",    res_id, 0);
    check("rst_sum",   res_sum, 0);
    check("rst_cout",  res_cout, 0);
    check("rst_ovf",   res_ovf, 0);
    rst       = 1'b0;
    req_valid = 4'h0;

    // single add from requester 0
    set_op(0, 32'h5, 32'h3, 1'b0);
    req_valid = 4'b0001;
    #1 check("add_ready", req_ready, 4'b0001);
    tick();
    req_valid = 4'h0;
    check("add_valid", res_valid, 1);
    check("add_id",    res_id, 0);
    check("add_sum",   res_sum, 32'h8);
    check("add_cout",  res_cout, 0);
    check("add_ovf",   res_ovf, 0);
    tick();
    check("drain_valid", res_valid, 0);
    check("drain_sum",   res_sum, 32'h8);

    // subtract and overflow corners from requester 2
    set_op(2, 32'h3, 32'h5, 1'b1);
    req_valid = 4'b0100;
    #1 check("sub_ready", req_ready, 4'b0100);
    tick();
    check("sub_id",   res_id, 2);
    check("sub_sum",  res_sum, 32'hFFFF_FFFE);
    check("sub_cout", res_cout, 0);
    check("sub_ovf",  res_ovf, 0);
    set_op(2, 32'h7FFF_FFFF, 32'h1, 1'b0);
    tick();
    check("povf_sum",  res_sum, 32'h8000_0000);
    check("povf_cout", res_cout, 0);
    check("povf_ovf",  res_ovf, 1);
    set_op(2, 32'h8000_0000, 32'h1, 1'b1);
    tick();
    check("novf_sum",  res_sum, 32'h7FFF_FFFF);
    check("novf_cout", res_cout, 1);
    check("novf_ovf",  res_ovf, 1);
    req_valid = 4'h0;
    tick();

    // wrap and skip: pointer sits at 3
    req_valid = 4'b1000;
    #1 check("wrap_ready3", req_ready, 4'b1000);
    tick();
    check("wrap_id3", res_id, 3);
    req_valid = 4'b0010;
    #1 check("skip_ready1", req_ready, 4'b0010);
    tick();
    check("skip_id1", res_id, 1);
    // only pointer==2 gives grant 2 for 0101 and grant 0 for 0011
    req_valid = 4'b0101;
    #1 check("ptr2_a", req_ready, 4'b0100);
    req_valid = 4'b0011;
    #1 check("ptr2_b", req_ready, 4'b0001);
    req_valid = 4'b0101;
    tick();
    req_valid = 4'b1000;
    tick();
    check("realign_id", res_id, 3);

    // round robin with all requesters valid
    for (int i = 0; i < 4; i++) set_op(i, 32'(i + 1), 32'h10, 1'b0);
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1 check("rr_gnt", req_ready, 64'(1 << (k % 4)));
      tick();
      check("rr_id",  res_id, 64'(k % 4));
      check("rr_sum", res_sum, 64'(17 + k % 4));
    end

    // back-pressure: result from requester 0 held for 5 cycles
    res_ready = 1'b0;
    req_valid = 4'b0010;
    set_op(1, 32'd10, 32'd20, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1 check("stall_ready", req_ready, 4'h0);
      check("stall_valid", res_valid, 1);
      check("stall_id",    res_id, 0);
      check("stall_sum",   res_sum, 32'h11);
      tick();
    end
    res_ready = 1'b1;
    #1 check("release_ready", req_ready, 4'b0010);
    tick();
    check("release_valid", res_valid, 1);
    check("release_id",    res_id, 1);
    check("release_sum",   res_sum, 32'd30);

    // reset while stalled discards the result and re-arms pointer at 0
    res_ready = 1'b0;
    req_valid = 4'b1001;
    tick();
    rst = 1'b1;
    #1 check("mrst_ready", req_ready, 4'h0);
    tick();
    rst = 1'b0;
    check("mrst_valid", res_valid, 0);
    check("mrst_sum",   res_sum, 0);
    res_ready = 1'b1;
    #1 check("mrst_gnt", req_ready, 4'b0001);
    tick();
    check("mrst_id",  res_id, 0);
    check("mrst_res", res_sum, 32'd17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
